micron_controller_board_test: RTL and testbench
===============================================

// Module: micron_controller_board_test
// PURPOSE
// - Board-level test harness for a Micron CellularRAM (PSRAM), operated in asynchronous mode.
// - Slide switches select a 2-bit word address and choose write or read; the module repeats that access continuously.
// - The low byte of the last word read is shown on debug_out (LEDs).
// - Sits between the FPGA pins and the external PSRAM, or its simulation model micron_sram.
// PARAMETERS
// - ACCESS_CYCLES  4  clk50MHz cycles that CE_L/WE_L or CE_L/OE_L stay asserted per access (80 ns >= 70 ns tAA/tWC).
// - RECOVER_CYCLES 1  cycles with all strobes deasserted between accesses.
// - SYNC_STAGES    2  flip-flop stages synchronising each switch input.
// PORTS
// - clk50MHz   in     1   50 MHz system clock; all logic is on its rising edge.
// - rst_L      in     1   asynchronous active-low reset.
// - sw_0       in     1   address bit 0 (LSb).
// - sw_1       in     1   address bit 1 (MSb).
// - sw_6       in     1   1 = write, 0 = read.
// - sw_7       in     1   enable; 0 = idle, memory deselected.
// - mwe_L      out    1   PSRAM write enable, active low.
// - moe_L      out    1   PSRAM output enable, active low.
// - madv_L     out    1   PSRAM address valid, active low.
// - mclk       out    1   PSRAM clock; constant 0 (async mode).
// - mub_L      out    1   upper byte enable, active low.
// - mlb_L      out    1   lower byte enable, active low.
// - mce_L      out    1   chip enable, active low.
// - mcre       out    1   configuration register enable; constant 0.
// - maddr      out    23  word address [22:0] = {21'b0, sw_1_s, sw_0_s}, latched per access.
// - debug_out  out    8   low byte of the last completed read.
// - mdata      inout  16  PSRAM data bus; driven only in WRITE, high-Z otherwise.
// BEHAVIOUR
// - Reset (async, rst_L=0), outputs:
//   - mce_L = moe_L = mwe_L = madv_L = mub_L = mlb_L = 1.
//   - mclk = 0, mcre = 0, maddr = 0, debug_out = 0, mdata = Z.
//   - FSM = IDLE; synchroniser flops cleared.
// - Switches pass through SYNC_STAGES flops. The suffix _s denotes synchronised values.
// - FSM states: IDLE, WRITE, READ, RECOVER. A down-counter cnt times each state.
// - IDLE: all strobes high, mdata = Z.
//   - sw_7_s = 1 starts an access next cycle: maddr <= {21'b0, sw_1_s, sw_0_s}.
//   - Goes to WRITE if sw_6_s = 1, else READ; cnt <= ACCESS_CYCLES-1.
// - WRITE: mce_L = mwe_L = madv_L = mub_L = mlb_L = 0, moe_L = 1.
//   - mdata driven with 16'h00A0 | maddr[1:0].
//   - Leaves when cnt = 0.
// - READ: mce_L = moe_L = madv_L = mub_L = mlb_L = 0, mwe_L = 1, mdata = Z.
//   - On the cycle cnt = 0, debug_out <= mdata[7:0].
//   - Leaves when cnt = 0.
// - RECOVER: all strobes high, mdata = Z, for RECOVER_CYCLES. Then returns to IDLE.
// - Per-access period = 1 + ACCESS_CYCLES + RECOVER_CYCLES = 6 cycles (120 ns).
// - Switch changes mid-access are ignored; address and direction are fixed at access start.
// - sw_7_s dropping mid-access: the current access completes, then the FSM idles.
// - mwe_L and moe_L are never low in the same cycle.
// - mdata is released in the same cycle mwe_L rises.
// - Strobes and mdata enable are registered outputs (no combinational glitches).
// - debug_out holds its value across idle and write periods; only completed reads update it.
// - rst_L asserted mid-access: strobes deassert immediately and the bus floats.
// TESTING
// - Reset: rst_L = 0 -> all strobes 1, mclk = 0, mcre = 0, debug_out = 8'h00, mdata = Z.
// - sw_7 = 0, other switches toggling -> mce_L stays 1 and mdata stays Z indefinitely.
// - sw_7 = 1, sw_6 = 1, addr 0 -> repeated 4-cycle mwe_L pulses with mdata = 16'h00A0 at maddr = 0.
//   - Model location 0 holds 16'h00A0.
// - Write addr 0, then sw_6 = 0 -> reads start within 3 cycles of sync delay plus 6 cycles; debug_out = 8'hA0.
// - Write all four addresses, then read addr 1/2/3 -> debug_out = A1/A2/A3 respectively.
// - Toggle sw_0 during READ -> maddr stable for that access; next access uses the new address.

Source files
------------

// File: rtl/micron_controller_board_test_if.sv
// PSRAM pin bundle between the board test controller and the CellularRAM (or its model).
// mdata stays a plain inout on the controller so the tristate resolves at the pin.
interface micron_controller_board_test_if;
    logic        mwe_L;
    logic        moe_L;
    logic        madv_L;
    logic        mclk;
    logic        mub_L;
    logic        mlb_L;
    logic        mce_L;
    logic        mcre;
    logic [22:0] maddr;

    modport master (
        output mwe_L, moe_L, madv_L, mclk, mub_L, mlb_L, mce_L, mcre, maddr
    );

    modport slave (
        input  mwe_L, moe_L, madv_L, mclk, mub_L, mlb_L, mce_L, mcre, maddr
    );
endinterface

// File: rtl/micron_controller_board_test.sv
// Board exerciser for a Micron CellularRAM in asynchronous mode: repeats a switch-selected
// read or write forever and shows the low byte of the last read on the LEDs.
module micron_controller_board_test #(
    parameter int ACCESS_CYCLES  = 4,
    parameter int RECOVER_CYCLES = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                          clk50MHz,
    input  logic                          rst_L,
    input  logic                          sw_0,
    input  logic                          sw_1,
    input  logic                          sw_6,
    input  logic                          sw_7,
    micron_controller_board_test_if.master mem,
    output logic [7:0]                    debug_out,
    inout  wire  [15:0]                   mdata
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    localparam int CNT_MAX = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] ACCESS_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic                        sw0_s, sw1_s, sw6_s, sw7_s;
    logic [1:0]                  state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic                        start;
    logic [1:0]                  maddr_q;
    logic                        mce_q, mwe_q, moe_q, drive_q;

    // Switch bundle order {sw_7, sw_6, sw_1, sw_0}; each bit passes through its own flop chain.
    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {sw_7, sw_6, sw_1, sw_0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign {sw7_s, sw6_s, sw1_s, sw0_s} = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (sw7_s) begin
                    start     = 1'b1;
                    state_nxt = sw6_s ? WRITE : READ;
                    cnt_nxt   = ACCESS_LOAD;
                end
            end
            WRITE, READ: begin
                if (cnt == '0) begin
                    state_nxt = RECOVER;
                    cnt_nxt   = RECOVER_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and bus enable are decoded from the next state so they leave a flop glitch-free.
    always_ff @(posedge clk50MHz or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            cnt       <= '0;
            maddr_q   <= '0;
            mce_q     <= 1'b1;
            mwe_q     <= 1'b1;
            moe_q     <= 1'b1;
            drive_q   <= 1'b0;
            debug_out <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            if (start) begin
                maddr_q <= {sw1_s, sw0_s};
            end
            mce_q   <= !((state_nxt == WRITE) || (state_nxt == READ));
            mwe_q   <= (state_nxt != WRITE);
            moe_q   <= (state_nxt != READ);
            drive_q <= (state_nxt == WRITE);
            if ((state == READ) && (cnt == '0)) begin
                debug_out <= mdata[7:0];
            end
        end
    end

    assign mem.mce_L  = mce_q;
    assign mem.madv_L = mce_q;
    assign mem.mub_L  = mce_q;
    assign mem.mlb_L  = mce_q;
    assign mem.mwe_L  = mwe_q;
    assign mem.moe_L  = moe_q;
    assign mem.mclk   = 1'b0;
    assign mem.mcre   = 1'b0;
    assign mem.maddr  = {21'b0, maddr_q};

    assign mdata = drive_q ? (16'h00A0 | {14'b0, maddr_q}) : 16'hzzzz;
endmodule

// File: tb/tb_micron_controller_board_test.sv
// Self-checking bench: a 4-word PSRAM model on the pins plus a word-level reference of
// what each address should hold and what the LEDs should show after each switch setting.
module tb_micron_controller_board_test;
    localparam int ACCESS = 4;
    localparam int PERIOD = 6;
    localparam int SETTLE = 20;

    logic       clk50MHz = 1'b0;
    logic       rst_L    = 1'b0;
    logic       sw_0     = 1'b0;
    logic       sw_1     = 1'b0;
    logic       sw_6     = 1'b0;
    logic       sw_7     = 1'b0;
    logic [7:0] debug_out;
    wire  [15:0] mdata;

    micron_controller_board_test_if mem_bus ();

    micron_controller_board_test dut (
        .clk50MHz  (clk50MHz),
        .rst_L     (rst_L),
        .sw_0      (sw_0),
        .sw_1      (sw_1),
        .sw_6      (sw_6),
        .sw_7      (sw_7),
        .mem       (mem_bus),
        .debug_out (debug_out),
        .mdata     (mdata)
    );

    always #10 clk50MHz = ~clk50MHz;

    // Pin-level PSRAM: only the two low address bits are ever exercised.
    logic [15:0] psram [4] = '{default: 16'h0000};

    always @(posedge clk50MHz) begin
        if (!mem_bus.mce_L && !mem_bus.mwe_L) psram[mem_bus.maddr[1:0]] <= mdata;
    end

    assign mdata = (!mem_bus.mce_L && !mem_bus.moe_L) ? psram[mem_bus.maddr[1:0]] : 16'hzzzz;

    // Reference: word each address should hold, and the byte the LEDs should show.
    logic [15:0] ref_mem [4] = '{default: 16'h0000};
    logic [7:0]  ref_debug   = 8'h00;

    int vectors    = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
            $error("[TB] check %s", tag);
        end
    endtask

    function automatic logic strobeLevel(input bit wr);
        return wr ? mem_bus.mwe_L : mem_bus.moe_L;
    endfunction

    task automatic waitStrobe(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk50MHz);
            if (strobeLevel(wr) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Catch one access pulse and check its address, data, exclusivity, width and repeat period.
    task automatic measurePulse(input bit wr, input logic [1:0] addr);
        bit ok;
        int width;
        int period;
        waitStrobe(wr, ok);
        checkOutput(wr ? "write_seen" : "read_seen", {31'b0, ok}, 32'd1);
        if (!ok) return;
        checkOutput("maddr", {9'b0, mem_bus.maddr}, {30'b0, addr});
        checkOutput("mce_L_active", {31'b0, mem_bus.mce_L}, 32'd0);
        checkOutput("other_strobe", {31'b0, wr ? mem_bus.moe_L : mem_bus.mwe_L}, 32'd1);
        if (wr) checkOutput("mdata_write", {16'b0, mdata}, {16'b0, 16'h00A0 | {14'b0, addr}});
        width = 1;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk50MHz);
            if (strobeLevel(wr)) break;
            width++;
        end
        period = width;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk50MHz);
            period++;
            if (!strobeLevel(wr)) break;
        end
        checkOutput("pulse_width", width, ACCESS);
        checkOutput("access_period", period, PERIOD);
    endtask

    task automatic applyStimulus(input bit en, input bit wr, input logic [1:0] addr);
        @(negedge clk50MHz);
        sw_7 = en;
        sw_6 = wr;
        {sw_1, sw_0} = addr;
        if (en && wr) ref_mem[addr] = 16'h00A0 | {14'b0, addr};
        if (en && !wr) ref_debug = ref_mem[addr][7:0];
        repeat (SETTLE) @(negedge clk50MHz);
    endtask

    task automatic runStep(input bit en, input bit wr, input logic [1:0] addr);
        applyStimulus(en, wr, addr);
        checkOutput("debug_out", {24'b0, debug_out}, {24'b0, ref_debug});
        if (en) begin
            measurePulse(wr, addr);
        end else begin
            for (int i = 0; i < 8; i++) begin
                sw_0 = 1'($urandom);
                sw_1 = 1'($urandom);
                sw_6 = 1'($urandom);
                @(negedge clk50MHz);
                checkOutput("idle_mce_L", {31'b0, mem_bus.mce_L}, 32'd1);
                checkOutput("idle_mwe_L", {31'b0, mem_bus.mwe_L}, 32'd1);
            end
        end
    endtask

    initial begin
        bit ok;
        bit en;
        bit wr;
        logic [1:0] addr;

        repeat (3) @(negedge clk50MHz);
        checkOutput("rst_mce_L", {31'b0, mem_bus.mce_L}, 32'd1);
        checkOutput("rst_strobes", {26'b0, mem_bus.mwe_L, mem_bus.moe_L, mem_bus.madv_L,
                                    mem_bus.mub_L, mem_bus.mlb_L, mem_bus.mce_L}, 32'h3F);
        checkOutput("rst_mclk_mcre", {30'b0, mem_bus.mclk, mem_bus.mcre}, 32'd0);
        checkOutput("rst_maddr", {9'b0, mem_bus.maddr}, 32'd0);
        checkOutput("rst_debug", {24'b0, debug_out}, 32'd0);
        rst_L = 1'b1;

        // Disabled with switches wandering, then fill every address and read three back.
        runStep(1'b0, 1'b1, 2'd3);
        runStep(1'b1, 1'b1, 2'd0);
        runStep(1'b1, 1'b0, 2'd0);
        runStep(1'b1, 1'b1, 2'd1);
        runStep(1'b1, 1'b1, 2'd2);
        runStep(1'b1, 1'b1, 2'd3);
        runStep(1'b1, 1'b0, 2'd1);
        runStep(1'b1, 1'b0, 2'd2);
        runStep(1'b1, 1'b0, 2'd3);

        // Moving the address switch inside a read must not disturb that access.
        applyStimulus(1'b1, 1'b0, 2'd1);
        waitStrobe(1'b0, ok);
        checkOutput("toggle_read_seen", {31'b0, ok}, 32'd1);
        sw_0 = 1'b0;
        for (int i = 0; i < ACCESS && !mem_bus.moe_L; i++) begin
            checkOutput("toggle_maddr_held", {9'b0, mem_bus.maddr}, 32'd1);
            @(negedge clk50MHz);
        end
        waitStrobe(1'b0, ok);
        checkOutput("toggle_next_seen", {31'b0, ok}, 32'd1);
        checkOutput("toggle_maddr_new", {9'b0, mem_bus.maddr}, 32'd0);
        ref_debug = ref_mem[0][7:0];
        repeat (SETTLE) @(negedge clk50MHz);
        checkOutput("toggle_debug", {24'b0, debug_out}, {24'b0, ref_debug});

        for (int s = 0; s < 20; s++) begin
            en   = ($urandom_range(0, 3) != 0);
            wr   = 1'($urandom);
            addr = 2'($urandom);
            runStep(en, wr, addr);
        end

        // Reset in the middle of a write pulse drops every strobe at once.
        applyStimulus(1'b1, 1'b1, 2'd2);
        waitStrobe(1'b1, ok);
        checkOutput("midrst_write_seen", {31'b0, ok}, 32'd1);
        #2 rst_L = 1'b0;
        #1;
        checkOutput("midrst_strobes", {26'b0, mem_bus.mwe_L, mem_bus.moe_L, mem_bus.madv_L,
                                       mem_bus.mub_L, mem_bus.mlb_L, mem_bus.mce_L}, 32'h3F);
        checkOutput("midrst_debug", {24'b0, debug_out}, 32'd0);
        ref_debug = 8'h00;
        repeat (2) @(negedge clk50MHz);
        rst_L = 1'b1;
        measurePulse(1'b1, 2'd2);
        runStep(1'b1, 1'b0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
